// File: rtl/inverter_stream_arbiter_pkg.sv
// Shared types for the two-source inverter stream arbiter.
// State encoding, source index type and reset constants.
package inverter_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef logic src_id_t;

  // Source 0 wins the first tie after reset.
  localparam src_id_t LAST_IDX_RST = 1'b1;

endpackage

// File: rtl/inverter_stream_arbiter_if.sv
// Stream bundle between two requesters, the arbiter and the inverter.
// slave = arbiter side, master = surrounding environment.
interface inverter_stream_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  s0_axis_valid;
  logic                  s0_axis_ready;
  logic [DATA_WIDTH-1:0] s0_axis_data;
  logic                  s0_axis_last;

  logic                  s1_axis_valid;
  logic                  s1_axis_ready;
  logic [DATA_WIDTH-1:0] s1_axis_data;
  logic                  s1_axis_last;

  logic                  m_axis_valid;
  logic                  m_axis_ready;
  logic [DATA_WIDTH-1:0] m_axis_data;
  logic                  m_axis_last;
  logic                  m_axis_id;

  modport slave (
    input  s0_axis_valid,
    output s0_axis_ready,
    input  s0_axis_data,
    input  s0_axis_last,
    input  s1_axis_valid,
    output s1_axis_ready,
    input  s1_axis_data,
    input  s1_axis_last,
    output m_axis_valid,
    input  m_axis_ready,
    output m_axis_data,
    output m_axis_last,
    output m_axis_id
  );

  modport master (
    output s0_axis_valid,
    input  s0_axis_ready,
    output s0_axis_data,
    output s0_axis_last,
    output s1_axis_valid,
    input  s1_axis_ready,
    output s1_axis_data,
    output s1_axis_last,
    input  m_axis_valid,
    output m_axis_ready,
    input  m_axis_data,
    input  m_axis_last,
    input  m_axis_id
  );

endinterface

// File: rtl/inverter_stream_arbiter_axis_reg_slice.sv
// One-entry registered valid/ready stage; accepts a new beat
// whenever empty or draining in the same cycle.
module axis_reg_slice #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic load;

  assign up_ready = !dn_valid || dn_ready;
  assign load     = up_valid && up_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else begin
      if (load) begin
        dn_valid <= 1'b1;
        dn_data  <= up_data;
      end else if (dn_ready) begin
        dn_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/inverter_stream_arbiter.sv
// Round-robin frame arbiter feeding the shared inverter datapath.
// ARB_BURST_LIMIT_EN caps each grant at MAX_BURST beats.
module inverter_stream_arbiter
  import inverter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 256
) (
  input  logic                        axi_clk,
  input  logic                        axi_rst,
  inverter_stream_arbiter_if.slave    bus,
  output logic                        busy
);

  if ((DATA_WIDTH % 8) != 0 || MAX_BURST < 1) begin : g_bad_param
    $error("inverter_stream_arbiter: invalid parameters");
  end

  arb_state_t state, state_nx;
  src_id_t    grant_idx, grant_nx;
  src_id_t    last_idx, last_nx;
  src_id_t    pick;

  logic                  any_req;
  logic                  src_valid;
  logic                  src_last;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_accept;
  logic                  release_grant;
  logic                  hit;
  logic                  slice_ready;
  logic [DATA_WIDTH+1:0] slice_in;
  logic [DATA_WIDTH+1:0] slice_out;

  assign any_req = bus.s0_axis_valid || bus.s1_axis_valid;
  assign pick    = (bus.s0_axis_valid && bus.s1_axis_valid)
                 ? !last_idx : bus.s1_axis_valid;

  always_comb begin
    src_valid = bus.s0_axis_valid;
    src_last  = bus.s0_axis_last;
    src_data  = bus.s0_axis_data;
    if (grant_idx) begin
      src_valid = bus.s1_axis_valid;
      src_last  = bus.s1_axis_last;
      src_data  = bus.s1_axis_data;
    end
  end

  assign busy = (state == GRANT);

  assign bus.s0_axis_ready = busy && !grant_idx && slice_ready;
  assign bus.s1_axis_ready = busy && grant_idx && slice_ready;

  assign src_accept    = busy && src_valid && slice_ready;
  assign release_grant = src_accept && (src_last || hit);

`ifdef ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] burst_cnt;

  // Counter is idle-cleared so each grant starts counting from zero.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      burst_cnt <= '0;
    end else if (src_accept) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  assign hit = src_accept && ((int'(burst_cnt) + 1) == MAX_BURST);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state     <= IDLE;
      grant_idx <= 1'b0;
      last_idx  <= LAST_IDX_RST;
    end else begin
      state     <= state_nx;
      grant_idx <= grant_nx;
      last_idx  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant_idx;
    last_nx  = last_idx;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = GRANT;
          grant_nx = pick;
          last_nx  = pick;
        end
      end
      GRANT: begin
        if (release_grant) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign slice_in = {grant_idx, src_last || hit, src_data};

  axis_reg_slice #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_slice (
    .clk      (axi_clk),
    .rst      (axi_rst),
    .up_valid (busy && src_valid),
    .up_ready (slice_ready),
    .up_data  (slice_in),
    .dn_valid (bus.m_axis_valid),
    .dn_ready (bus.m_axis_ready),
    .dn_data  (slice_out)
  );

  assign bus.m_axis_data = slice_out[DATA_WIDTH-1:0];
  assign bus.m_axis_last = slice_out[DATA_WIDTH];
  assign bus.m_axis_id   = slice_out[DATA_WIDTH+1];

endmodule

// File: tb/tb_inverter_stream_arbiter.sv
// Bench for inverter_stream_arbiter: per-source beat lists as the
// reference, directed scenarios plus randomized valid/ready traffic.
module tb_inverter_stream_arbiter;

  localparam int DW   = 32;
  localparam int MAXB = 4;
  localparam int NB   = 256;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  inverter_stream_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  inverter_stream_arbiter #(
    .DATA_WIDTH(DW),
    .MAX_BURST (MAXB)
  ) dut (
    .axi_clk(clk),
    .axi_rst(rst),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sd   [2][NB];
  logic          sl   [2][NB];
  int            spos [2][NB];
  int            sn [2];
  int            sp [2];
  int            ep [2];
  logic          sv [2];
  logic          took [2];

  bit   cont;
  bit   rand_ready;
  logic mr_force;

  int vectors;
  int miscompares;
  int cyc;

  int log_id[$];
  int log_cyc[$];
  int log_first[$];

  logic          in_frame;
  logic          cur_id;
  logic          hold;
  logic [DW-1:0] hold_data;
  logic          hold_last;
  logic          hold_id;
  logic          last_r0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_beat(input int k, input logic [DW-1:0] d,
                          input logic l, input int pos);
    if (sn[k] < NB) begin
      sd[k][sn[k]]   = d;
      sl[k][sn[k]]   = l;
      spos[k][sn[k]] = pos;
      sn[k]++;
    end
  endtask

  task automatic add_frame(input int k, input int len);
    for (int i = 0; i < len; i++)
      add_beat(k, DW'($urandom), i == len - 1, i);
  endtask

  // A grant segment ends on the frame's own last or every MAXB beats.
  function automatic logic exp_last(input int k, input int i);
    return sl[k][i] || (LIMIT && (((spos[k][i] + 1) % MAXB) == 0));
  endfunction

  function automatic logic [DW-1:0] cur_data(input int k);
    logic [DW-1:0] d;
    d = '0;
    if (sp[k] < sn[k]) d = sd[k][sp[k]];
    return d;
  endfunction

  function automatic logic cur_last(input int k);
    logic l;
    l = 1'b0;
    if (sp[k] < sn[k]) l = sl[k][sp[k]];
    return l;
  endfunction

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      if (!(sv[k] && !took[k]))
        sv[k] = (sp[k] < sn[k]) && (cont || $urandom_range(0, 3) != 0);
    end
    bus.s0_axis_valid = sv[0];
    bus.s0_axis_data  = cur_data(0);
    bus.s0_axis_last  = cur_last(0);
    bus.s1_axis_valid = sv[1];
    bus.s1_axis_data  = cur_data(1);
    bus.s1_axis_last  = cur_last(1);
    bus.m_axis_ready  = rand_ready ? ($urandom_range(0, 2) != 0) : mr_force;
  endtask

  task automatic step();
    logic          a0, a1, oa, ol, oid;
    logic [DW-1:0] od;
    int            k;
    @(negedge clk);
    a0  = bus.s0_axis_valid && bus.s0_axis_ready;
    a1  = bus.s1_axis_valid && bus.s1_axis_ready;
    oa  = bus.m_axis_valid && bus.m_axis_ready;
    od  = bus.m_axis_data;
    ol  = bus.m_axis_last;
    oid = bus.m_axis_id;
    last_r0 = bus.s0_axis_ready;
    if (hold) begin
      check("hold_valid", 64'(bus.m_axis_valid), 64'(1'b1));
      check("hold_data", 64'(od), 64'(hold_data));
      check("hold_last_id", 64'({ol, oid}), 64'({hold_last, hold_id}));
    end
    hold      = bus.m_axis_valid && !bus.m_axis_ready;
    hold_data = od;
    hold_last = ol;
    hold_id   = oid;
    check("ready_excl",
          64'(bus.s0_axis_ready & bus.s1_axis_ready), 64'(0));
    if (!busy)
      check("idle_ready",
            64'({bus.s0_axis_ready, bus.s1_axis_ready}), 64'(0));
    @(posedge clk);
    #1;
    cyc++;
    took[0] = a0;
    took[1] = a1;
    if (oa) begin
      k = int'(oid);
      check("out_order", 64'(ep[k] < sp[k]), 64'(1));
      if (ep[k] < sn[k]) begin
        check("out_data", 64'(od), 64'(sd[k][ep[k]]));
        check("out_last", 64'(ol), 64'(exp_last(k, ep[k])));
      end
      if (in_frame) check("frame_atomic", 64'(oid), 64'(cur_id));
      else log_first.push_back(k);
      in_frame = !ol;
      cur_id   = oid;
      log_id.push_back(k);
      log_cyc.push_back(cyc);
      ep[k]++;
    end
    if (a0 || a1) begin
      k = a1 ? 1 : 0;
      check("lat_valid", 64'(bus.m_axis_valid), 64'(1));
      check("lat_data", 64'(bus.m_axis_data), 64'(sd[k][sp[k]]));
      check("lat_id", 64'(bus.m_axis_id), 64'(k));
      check("busy_after", 64'(busy), 64'(!exp_last(k, sp[k])));
      sp[k]++;
    end
    drive();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((ep[0] < sn[0] || ep[1] < sn[1] || bus.m_axis_valid)
           && n < limit) begin
      step();
      n++;
    end
    check("drain_done", 64'(ep[0] == sn[0] && ep[1] == sn[1]), 64'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctl"},
          64'({bus.m_axis_valid, bus.m_axis_last, bus.m_axis_id, busy,
               bus.s0_axis_ready, bus.s1_axis_ready}), 64'(0));
    check({tag, "_data"}, 64'(bus.m_axis_data), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sn[k] = 0; sp[k] = 0; ep[k] = 0;
      sv[k] = 1'b0; took[k] = 1'b1;
    end
    in_frame = 1'b0;
    hold     = 1'b0;
    log_id.delete();
    log_cyc.delete();
    log_first.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    cont        = 1'b1;
    rand_ready  = 1'b0;
    mr_force    = 1'b1;
    do_reset();

    // Single 4-beat frame on source 0
    for (int i = 0; i < 4; i++)
      add_beat(0, DW'(32'h11111111 * (i + 1)), i == 3, i);
    drive();
    drain(100);
    check("t1_busy", 64'(busy), 64'(0));
    check("t1_count", 64'(log_id.size()), 64'(4));
    foreach (log_id[i]) check("t1_id", 64'(log_id[i]), 64'(0));

    // Tie from reset: source 0 first, one idle cycle, then source 1
    do_reset();
    add_frame(0, 2);
    add_frame(1, 2);
    drive();
    drain(100);
    check("t2_count", 64'(log_id.size()), 64'(4));
    if (log_id.size() == 4) begin
      for (int i = 0; i < 4; i++)
        check("t2_id", 64'(log_id[i]), 64'(i / 2));
      check("t2_gap", 64'(log_cyc[2] - log_cyc[1]), 64'(2));
    end

    // Backpressure for 5 cycles mid-frame
    do_reset();
    add_frame(0, 4);
    drive();
    for (int n = 0; n < 20 && log_id.size() < 2; n++) step();
    mr_force = 1'b0;
    drive();
    for (int n = 0; n < 5; n++) begin
      step();
      check("t3_s0_ready", 64'(last_r0), 64'(0));
    end
    mr_force = 1'b1;
    drive();
    drain(100);
    check("t3_count", 64'(log_id.size()), 64'(4));

    // Continuous requests: grants alternate
    do_reset();
    for (int f = 0; f < 3; f++) begin
      add_frame(0, $urandom_range(1, 4));
      add_frame(1, $urandom_range(1, 4));
    end
    drive();
    drain(500);
    check("t4_frames", 64'(log_first.size()), 64'(6));
    foreach (log_first[i])
      check("t4_grant", 64'(log_first[i]), 64'(i % 2));

    // Asynchronous reset after beat 2 of 4
    do_reset();
    add_frame(0, 4);
    drive();
    for (int n = 0; n < 20 && sp[0] < 2; n++) step();
    #2 rst = 1'b1;
    #1 check_reset_values("t5_async");
    do_reset();
    add_frame(0, 1);
    add_frame(1, 1);
    drive();
    drain(100);
    check("t5_frames", 64'(log_first.size()), 64'(2));
    if (log_first.size() > 0)
      check("t5_tie", 64'(log_first[0]), 64'(0));

`ifdef ARB_BURST_LIMIT_EN
    // Burst cap splits a 6-beat frame around source 1's frame
    do_reset();
    add_frame(0, 6);
    add_frame(1, 2);
    drive();
    drain(200);
    check("t6_count", 64'(log_id.size()), 64'(8));
    if (log_id.size() == 8) begin
      for (int i = 0; i < 8; i++)
        check("t6_id", 64'(log_id[i]), 64'((i == 4 || i == 5) ? 1 : 0));
    end
`endif

    // Random valid gaps and random downstream ready
    do_reset();
    cont       = 1'b0;
    rand_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      add_frame(0, $urandom_range(1, 9));
      add_frame(1, $urandom_range(1, 9));
    end
    drive();
    drain(4000);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inverter_stream_arbiter.md
# inverter_stream_arbiter

Two-input AXI-Stream frame arbiter that shares the single byte-inverter datapath between two upstream requesters. It grants one source at a time for a whole frame, delimited by `tlast`, alternating round-robin between sources, and drives the inverter's slave port through a one-entry registered output stage. It also emits a source ID so downstream logic can route the inverted frame back to its requester.

## Interface
Parameters:
- `DATA_WIDTH`, 32: stream width in bits; must be a multiple of 8.
- `MAX_BURST`, 256: beat limit per grant. Used only when `ARB_BURST_LIMIT_EN` is defined.

Ports:
- `axi_clk`, in, 1: single clock; all logic is on its rising edge.
- `axi_rst`, in, 1: reset, asynchronous, active-high.
- `s0_axis_valid`, `s1_axis_valid`, in, 1 each: source k has a beat.
- `s0_axis_ready`, `s1_axis_ready`, out, 1 each: arbiter accepts a beat from source k.
- `s0_axis_data`, `s1_axis_data`, in, DATA_WIDTH each: source payload.
- `s0_axis_last`, `s1_axis_last`, in, 1 each: last beat of the frame.
- `m_axis_valid`, out, 1: beat toward the inverter.
- `m_axis_ready`, in, 1: inverter accepts.
- `m_axis_data`, out, DATA_WIDTH: forwarded payload.
- `m_axis_last`, out, 1: forwarded last.
- `m_axis_id`, out, 1: source index of the current beat.
- `busy`, out, 1: a grant is active.

## Operation
- States: `IDLE` and `GRANT`, plus registers `grant_idx` (1 bit) and `last_idx` (1 bit, the most recently granted source).
- In `IDLE`, selection is round-robin:
  - One source valid: grant it.
  - Both valid: grant `!last_idx`.
  - On the next edge: move to `GRANT`, latch `grant_idx`, and set `last_idx <= grant_idx`.
- In `GRANT`:
  - `sK_axis_ready = (grant_idx==K) && (!m_axis_valid || m_axis_ready)`.
  - The non-granted ready is 0.
- Accepted beat (`valid && ready` on the granted source):
  - Load `m_axis_data` and `m_axis_last` from the source, and `m_axis_id <= grant_idx`.
  - Set `m_axis_valid <= 1`.
- `m_axis_valid` clears when `m_axis_ready` is high and no new beat is accepted in the same cycle.
- While `m_axis_valid && !m_axis_ready`, data, last and id stay stable. There is no loss and no duplication.
- Grant release: an accepted beat with `last=1` moves the FSM to `IDLE`.
- Payload is passed unmodified. Inversion happens downstream.
- `busy = (state==GRANT)`.
- Reset, including mid-frame:
  - State returns to `IDLE`, `grant_idx=0`, `last_idx=1` (source 0 wins the first tie).
  - Burst count returns to 0.
  - Any partial frame is abandoned. Upstream restarts frames after reset.

## Timing
- Reset values:
  - `m_axis_valid=0`, `m_axis_data=0`, `m_axis_last=0`, `m_axis_id=0`, `busy=0`.
  - Both `sK_axis_ready=0`, because no grant is held in `IDLE`.
- Latency: a beat accepted at edge N is presented on `m_*` after edge N; one register stage.
- Throughput: one beat per cycle within a frame while `m_axis_ready=1`.
- Arbitration costs exactly one `IDLE` cycle between frames; no beat is accepted in that cycle.
- Single-beat frame (`last` on the first beat): `GRANT` lasts one accepting cycle, then `IDLE`.
- A source dropping `valid` mid-frame keeps its grant. The other source waits; there is no preemption.
- `m_axis_ready` deasserted for any length stalls the granted source only. The grant is held.

## Configuration
- `ARB_BURST_LIMIT_EN` defined:
  - A beat counter (width `$clog2(MAX_BURST+1)`) increments on each accepted beat and clears on entering `GRANT`.
  - When the counter reaches `MAX_BURST` on an accepted beat, the FSM returns to `IDLE` even without `last`, and `m_axis_last` is forced to 1 on that beat.
  - The frame's remainder competes again on a later grant.
- `ARB_BURST_LIMIT_EN` undefined: the grant is released only by `last`, and `MAX_BURST` is ignored.

## Structure
- Shared package `inverter_pkg` holds:
  - The state enum `arb_state_t {IDLE, GRANT}`.
  - The source-index typedef `src_id_t` (1 bit).
  - The reset constant for `last_idx`.
- One natural sub-module is `axis_reg_slice`: the one-entry output register with the valid/ready rule above, parameterised by payload width (`DATA_WIDTH+2` for data, last and id).
- The FSM and round-robin pick stay in the top module.

## Test plan
- Source 0 only, 4-beat frame 0x11111111..0x44444444 with `m_axis_ready=1`:
  - `m_*` outputs the same 4 beats, each one cycle after acceptance.
  - `m_axis_id=0`, `m_axis_last` only on beat 4, `busy` falls after beat 4.
- Both sources valid from reset, 2-beat frames each:
  - Source 0 frame goes out first, then one idle cycle, then source 1 frame.
  - `m_axis_id` is 0,0,1,1.
- Backpressure: hold `m_axis_ready=0` for 5 cycles mid-frame.
  - `m_axis_data` stays stable and `s0_axis_ready=0` throughout.
  - No beat is lost or duplicated after release.
- Continuous requests from both sources for 6 frames: grants alternate 0,1,0,1,0,1.
- Assert `axi_rst` mid-frame after beat 2 of 4:
  - All outputs return to reset values asynchronously.
  - After release, a new tie grants source 0.
- With `ARB_BURST_LIMIT_EN` and `MAX_BURST=4`, a 6-beat frame on source 0 with source 1 waiting:
  - Beat 4 goes out with `m_axis_last=1`.
  - Source 1's frame follows.
  - Source 0's remaining 2 beats go out afterwards.
